hms_timekeeper: RTL and testbench
=================================

# hms_timekeeper

Parametrised BCD time-of-day core: hours, minutes and seconds from one fast clock, with a runtime-selectable 12/24-hour display, validated time loading and an optional alarm comparator. It supersedes the separate second-divider and hour-counter chain. It sits between the board clock and the seven-segment display multiplexer.

## Interface
Parameters:
- CLK_DIV, 50_000_000, clk cycles per second; legal range ≥ 2.
- DIV_W, $clog2(CLK_DIV), divider counter width.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  1 = divider counts; 0 = time and divider frozen.
- mode_12h  in  1  0 = 24-hour display, 1 = 12-hour display.
- set  in  1  load-time strobe, sampled every cycle.
- set_h1, set_h0, set_m1, set_m0, set_s1, set_s0  in  4 each  BCD time to load, interpreted per mode_12h.
- set_pm  in  1  PM flag for the load; used only when mode_12h=1.
- alarm_load  in  1  load alarm time (24-hour BCD HH:MM).
- alarm_h1, alarm_h0, alarm_m1, alarm_m0  in  4 each  alarm time digits.
- alarm_arm  in  1  level; 1 = alarm enabled.
- alarm_ack  in  1  clears alarm.
- h1, h0, m1, m0, s1, s0  out  4 each  displayed BCD digits.
- pm  out  1  1 when the internal hour is ≥ 12, in both modes.
- sec_tick  out  1  one-cycle pulse; time advanced this cycle.
- day_wrap  out  1  one-cycle pulse with the 23:59:59→00:00:00 step.
- set_err  out  1  one-cycle pulse; the last set or alarm_load was rejected.
- alarm  out  1  alarm active, sticky.

## Operation
- Internal state: the 24-hour BCD registers hr (00–23), min, sec; the divider div; and the alarm registers.
- Divider: when run=1, div counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and the time advances 1 s. When run=0, div holds.
- Carry chain: s0 9→0 carries into s1; s1 5→0 carries into m0; m0 and m1 follow the same rule. Hours run 23→00, which also pulses day_wrap.
- Display decode is combinational from hr and mode_12h:
  - 24-hour mode shows hr directly.
  - 12-hour mode: hr 0 shows 12; hr 13–23 shows hr−12; otherwise hr.
- Set validation:
  - Every digit ≤ 9; s1 ≤ 5; m1 ≤ 5.
  - 24-hour mode: hour 00–23.
  - 12-hour mode: hour 01–12. Conversion: 12 AM→00, 12 PM→12, otherwise h + 12·set_pm.
- Valid set: load the converted time and clear div to 0; no sec_tick is generated that cycle.
- Invalid set: state unchanged, set_err pulses.
- set held high: reloads every cycle and the time does not advance.
- Priority per cycle: rst > set > tick.
- alarm_load: validated as 24-hour HH:MM; an invalid load pulses set_err.
- Alarm trigger: asserts on the tick that makes hr:min:sec equal alarm HH:MM:00 while alarm_arm=1. It stays high until alarm_ack=1 or alarm_arm=0. alarm_ack has priority over a same-cycle trigger.

## Timing
- Reset values:
  - Internal time 00:00:00, div=0, alarm time 00:00.
  - All pulse outputs 0; alarm=0.
  - Display after reset: 00:00:00 in 24-hour mode; 12:00:00 with pm=0 in 12-hour mode.
- First sec_tick comes CLK_DIV cycles after the rst-low edge when run=1.
- sec_tick, day_wrap and set_err are registered. Each is high in the cycle the new state is visible.
- Digits are registered state plus combinational decode. A mode_12h change is visible in the same cycle with no state change.
- A loaded time is visible the cycle after set is sampled. The next tick follows a full CLK_DIV cycles later.
- rst during counting or during a held set returns all state to reset values on that edge.

## Configuration
- ALARM_EN defined: alarm registers, comparator and the alarm output are built.
- ALARM_EN undefined:
  - All alarm ports remain. alarm_* inputs are ignored and alarm is tied to 0.
  - alarm_load never causes set_err.

## Test plan
All scenarios use CLK_DIV=4.
- Reset then run=1 for 16 cycles -> exactly 4 sec_tick pulses, display 00:00:04, pm=0.
- Set 23:59:58 in 24-hour mode, run 8 cycles -> 23:59:59, then 00:00:00 with day_wrap=1 for one cycle, pm 1→0.
- mode_12h=1 and set 12:00:00 with set_pm=0 -> internal 00, display 12:00:00 with pm=0. Then set 08:00:00 with set_pm=1 -> pm=1; switching to mode_12h=0 shows 20:00:00 the same cycle.
- Invalid loads: set 24:00:00 (24-hour), 00:30:00 (12-hour) and m1=6 -> each pulses set_err once, time unchanged. A set in the same cycle as a tick -> loaded value wins and div=0.
- ALARM_EN: alarm 00:01 armed, set 00:00:58 -> alarm rises on the 00:01:00 tick, stays high through later ticks, and clears on alarm_ack. Without ALARM_EN the same stimulus keeps alarm=0.
- run=0 for 20 cycles mid-second -> time and div frozen. Setting run=1 resumes the remaining count with no lost or extra tick.

Source files
------------

// File: rtl/hms_timekeeper.sv
// hms_timekeeper: BCD HH:MM:SS core with runtime 12/24-hour display and validated time loading.
// Define ALARM_EN to build the alarm registers and comparator; otherwise alarm is tied low.
module hms_timekeeper #(
    parameter int CLK_DIV = 50_000_000,
    parameter int DIV_W   = $clog2(CLK_DIV)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mode_12h,
    input  logic       set,
    input  logic [3:0] set_h1,
    input  logic [3:0] set_h0,
    input  logic [3:0] set_m1,
    input  logic [3:0] set_m0,
    input  logic [3:0] set_s1,
    input  logic [3:0] set_s0,
    input  logic       set_pm,
    input  logic       alarm_load,
    input  logic [3:0] alarm_h1,
    input  logic [3:0] alarm_h0,
    input  logic [3:0] alarm_m1,
    input  logic [3:0] alarm_m0,
    input  logic       alarm_arm,
    input  logic       alarm_ack,
    output logic [3:0] h1,
    output logic [3:0] h0,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic       pm,
    output logic       sec_tick,
    output logic       day_wrap,
    output logic       set_err,
    output logic       alarm
);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [3:0] hr1, hr0, mn1, mn0, sc1, sc0;
    logic [3:0] nh1, nh0, nm1, nm0, ns1, ns0;
    logic [DIV_W-1:0] div;
    logic       wrap, tick;
    logic       set_ok, alarm_err;
    logic [4:0] hr_bin, disp_bin, set_raw, set_hour;
    logic [7:0] disp_bcd, set_bcd;

    function automatic logic [7:0] to_bcd(input logic [4:0] v);
        logic [3:0] t;
        if (v >= 5'd20)      t = 4'd2;
        else if (v >= 5'd10) t = 4'd1;
        else                 t = 4'd0;
        return {t, 4'(v - 5'(t) * 5'd10)};
    endfunction

    assign tick = !set && run && (div == DIV_MAX);

    // One-second increment with BCD carries; hours wrap 23 -> 00.
    always_comb begin
        nh1 = hr1; nh0 = hr0; nm1 = mn1; nm0 = mn0; ns1 = sc1; ns0 = sc0;
        wrap = 1'b0;
        if (sc0 != 4'd9) ns0 = sc0 + 4'd1;
        else begin
            ns0 = 4'd0;
            if (sc1 != 4'd5) ns1 = sc1 + 4'd1;
            else begin
                ns1 = 4'd0;
                if (mn0 != 4'd9) nm0 = mn0 + 4'd1;
                else begin
                    nm0 = 4'd0;
                    if (mn1 != 4'd5) nm1 = mn1 + 4'd1;
                    else begin
                        nm1 = 4'd0;
                        if (hr1 == 4'd2 && hr0 == 4'd3) begin
                            nh1 = 4'd0; nh0 = 4'd0; wrap = 1'b1;
                        end else if (hr0 == 4'd9) begin
                            nh0 = 4'd0; nh1 = hr1 + 4'd1;
                        end else begin
                            nh0 = hr0 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Load validation and 12-hour to 24-hour conversion (12 AM is hour 0).
    always_comb begin
        set_raw  = 5'(set_h1[1:0]) * 5'd10 + 5'(set_h0);
        set_ok   = (set_h0 <= 4'd9) && (set_m1 <= 4'd5) && (set_m0 <= 4'd9)
                && (set_s1 <= 4'd5) && (set_s0 <= 4'd9);
        set_hour = set_raw;
        if (mode_12h) begin
            set_ok = set_ok && ((set_h1 == 4'd0 && set_h0 != 4'd0)
                             || (set_h1 == 4'd1 && set_h0 <= 4'd2));
            if (set_raw == 5'd12) set_hour = set_pm ? 5'd12 : 5'd0;
            else                  set_hour = set_raw + (set_pm ? 5'd12 : 5'd0);
        end else begin
            set_ok = set_ok && ((set_h1 <= 4'd1) || (set_h1 == 4'd2 && set_h0 <= 4'd3));
        end
        set_bcd = to_bcd(set_hour);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {hr1, hr0, mn1, mn0, sc1, sc0} <= '0;
            div      <= '0;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            set_err  <= (set && !set_ok) || alarm_err;
            if (set) begin
                if (set_ok) begin
                    {hr1, hr0} <= set_bcd;
                    {mn1, mn0, sc1, sc0} <= {set_m1, set_m0, set_s1, set_s0};
                    div <= '0;
                end
            end else if (run) begin
                if (div == DIV_MAX) begin
                    div <= '0;
                    {hr1, hr0, mn1, mn0, sc1, sc0} <= {nh1, nh0, nm1, nm0, ns1, ns0};
                    sec_tick <= 1'b1;
                    day_wrap <= wrap;
                end else begin
                    div <= div + 1'b1;
                end
            end
        end
    end

    assign hr_bin   = 5'(hr1[1:0]) * 5'd10 + 5'(hr0);
    assign pm       = (hr_bin >= 5'd12);
    assign disp_bin = !mode_12h       ? hr_bin :
                      (hr_bin == 5'd0) ? 5'd12 :
                      (hr_bin >= 5'd13) ? hr_bin - 5'd12 : hr_bin;
    assign disp_bcd = to_bcd(disp_bin);
    assign {h1, h0} = disp_bcd;
    assign {m1, m0, s1, s0} = {mn1, mn0, sc1, sc0};

`ifdef ALARM_EN
    logic [3:0] al_h1, al_h0, al_m1, al_m0;
    logic       alarm_ok, alarm_hit, alarm_r;

    assign alarm_ok  = ((alarm_h1 <= 4'd1) || (alarm_h1 == 4'd2 && alarm_h0 <= 4'd3))
                    && (alarm_h0 <= 4'd9) && (alarm_m1 <= 4'd5) && (alarm_m0 <= 4'd9);
    assign alarm_err = alarm_load && !alarm_ok;
    assign alarm_hit = tick && alarm_arm && ({ns1, ns0} == 8'h00)
                    && ({nh1, nh0, nm1, nm0} == {al_h1, al_h0, al_m1, al_m0});

    // Acknowledge or disarm wins over a trigger landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            {al_h1, al_h0, al_m1, al_m0} <= '0;
            alarm_r <= 1'b0;
        end else begin
            if (alarm_load && alarm_ok)
                {al_h1, al_h0, al_m1, al_m0} <= {alarm_h1, alarm_h0, alarm_m1, alarm_m0};
            if (alarm_ack || !alarm_arm) alarm_r <= 1'b0;
            else if (alarm_hit)          alarm_r <= 1'b1;
        end
    end
    assign alarm = alarm_r;
`else
    logic unused_alarm;
    assign unused_alarm = ^{alarm_load, alarm_h1, alarm_h0, alarm_m1, alarm_m0,
                            alarm_arm, alarm_ack, tick};
    assign alarm_err = 1'b0;
    assign alarm     = 1'b0;
`endif
endmodule

// File: tb/tb_hms_timekeeper.sv
// tb_hms_timekeeper: directed and randomized checks of hms_timekeeper (CLK_DIV=4) against a
// seconds-of-day reference model; alarm expectations follow the ALARM_EN build macro.
module tb_hms_timekeeper;
    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1, run = 1'b0, mode_12h = 1'b0, set = 1'b0, set_pm = 1'b0;
    logic [3:0] set_h1 = '0, set_h0 = '0, set_m1 = '0, set_m0 = '0, set_s1 = '0, set_s0 = '0;
    logic alarm_load = 1'b0, alarm_arm = 1'b0, alarm_ack = 1'b0;
    logic [3:0] alarm_h1 = '0, alarm_h0 = '0, alarm_m1 = '0, alarm_m0 = '0;
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic pm, sec_tick, day_wrap, set_err, alarm;

    hms_timekeeper #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .run(run), .mode_12h(mode_12h), .set(set),
        .set_h1(set_h1), .set_h0(set_h0), .set_m1(set_m1), .set_m0(set_m0),
        .set_s1(set_s1), .set_s0(set_s0), .set_pm(set_pm),
        .alarm_load(alarm_load), .alarm_h1(alarm_h1), .alarm_h0(alarm_h0),
        .alarm_m1(alarm_m1), .alarm_m0(alarm_m0), .alarm_arm(alarm_arm), .alarm_ack(alarm_ack),
        .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
        .pm(pm), .sec_tick(sec_tick), .day_wrap(day_wrap), .set_err(set_err), .alarm(alarm)
    );

    always #5 clk = ~clk;

    int tests = 0, failures = 0;
    int secs = 0, cyc_in_sec = 0, alarm_min = 0, tick_count = 0;
    bit alarm_on = 0, exp_tick = 0, exp_wrap = 0, exp_err = 0;

    // Reference model: time is a count of seconds since midnight.
    task automatic modelStep();
        int hour, minute, second, al_hour, al_min;
        bit ok, al_ok, trig;
        exp_tick = 0; exp_wrap = 0; exp_err = 0; trig = 0;
        if (rst) begin
            secs = 0; cyc_in_sec = 0; alarm_min = 0; alarm_on = 0;
            return;
        end
        hour   = int'(set_h1) * 10 + int'(set_h0);
        minute = int'(set_m1) * 10 + int'(set_m0);
        second = int'(set_s1) * 10 + int'(set_s0);
        ok = (set_h0 <= 9) && (set_m0 <= 9) && (set_s0 <= 9) && (minute < 60) && (second < 60);
        if (mode_12h) begin
            ok = ok && hour >= 1 && hour <= 12;
            hour = hour % 12 + (set_pm ? 12 : 0);
        end else begin
            ok = ok && hour <= 23;
        end
        al_hour = int'(alarm_h1) * 10 + int'(alarm_h0);
        al_min  = int'(alarm_m1) * 10 + int'(alarm_m0);
        al_ok   = (alarm_h0 <= 9) && (alarm_m0 <= 9) && (al_hour <= 23) && (al_min < 60);
        if (set && !ok) exp_err = 1;
`ifdef ALARM_EN
        if (alarm_load && !al_ok) exp_err = 1;
`endif
        if (set) begin
            if (ok) begin
                secs = hour * 3600 + minute * 60 + second;
                cyc_in_sec = 0;
            end
        end else if (run) begin
            if (cyc_in_sec == CLK_DIV - 1) begin
                cyc_in_sec = 0;
                secs = (secs + 1) % 86400;
                exp_tick = 1;
                exp_wrap = (secs == 0);
                trig = alarm_arm && (secs == alarm_min * 60);
            end else begin
                cyc_in_sec++;
            end
        end
`ifdef ALARM_EN
        if (alarm_ack || !alarm_arm) alarm_on = 0;
        else if (trig) alarm_on = 1;
        if (alarm_load && al_ok) alarm_min = al_hour * 60 + al_min;
`endif
    endtask

    task automatic checkOutput(input string tag);
        int hr, dh;
        logic [23:0] exp_digits;
        hr = secs / 3600;
        dh = mode_12h ? ((hr % 12 == 0) ? 12 : hr % 12) : hr;
        exp_digits = {4'(dh / 10), 4'(dh % 10), 4'((secs / 60) % 60 / 10),
                      4'((secs / 60) % 60 % 10), 4'(secs % 60 / 10), 4'(secs % 60 % 10)};
        tests++;
        assert ({h1, h0, m1, m0, s1, s0} === exp_digits) else begin
            failures++;
            $error("FAIL %s digits: observed %h expected %h", tag, {h1, h0, m1, m0, s1, s0}, exp_digits);
        end
        tests++;
        assert (pm === (hr >= 12)) else begin
            failures++; $error("FAIL %s pm: observed %b expected %b", tag, pm, hr >= 12);
        end
        tests++;
        assert (sec_tick === exp_tick) else begin
            failures++; $error("FAIL %s sec_tick: observed %b expected %b", tag, sec_tick, exp_tick);
        end
        tests++;
        assert (day_wrap === exp_wrap) else begin
            failures++; $error("FAIL %s day_wrap: observed %b expected %b", tag, day_wrap, exp_wrap);
        end
        tests++;
        assert (set_err === exp_err) else begin
            failures++; $error("FAIL %s set_err: observed %b expected %b", tag, set_err, exp_err);
        end
        tests++;
        assert (alarm === alarm_on) else begin
            failures++; $error("FAIL %s alarm: observed %b expected %b", tag, alarm, alarm_on);
        end
    endtask

    // Clock n cycles with the current inputs, checking outputs at each falling edge.
    task automatic applyStimulus(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            if (sec_tick) tick_count++;
            checkOutput(tag);
        end
    endtask

    task automatic loadTime(input int h, input int m, input int s, input bit p, input string tag);
        set_h1 = 4'(h / 10); set_h0 = 4'(h % 10);
        set_m1 = 4'(m / 10); set_m0 = 4'(m % 10);
        set_s1 = 4'(s / 10); set_s0 = 4'(s % 10);
        set_pm = p; set = 1'b1;
        applyStimulus(1, tag);
        set = 1'b0;
    endtask

    task automatic loadAlarm(input int h, input int m, input string tag);
        alarm_h1 = 4'(h / 10); alarm_h0 = 4'(h % 10);
        alarm_m1 = 4'(m / 10); alarm_m0 = 4'(m % 10);
        alarm_load = 1'b1;
        applyStimulus(1, tag);
        alarm_load = 1'b0;
    endtask

    initial begin
        applyStimulus(2, "reset");
        mode_12h = 1'b1; #1; checkOutput("reset_12h");
        mode_12h = 1'b0; #1;

        rst = 1'b0; run = 1'b1; tick_count = 0;
        applyStimulus(16, "first_16");
        tests++;
        assert (tick_count === 4) else begin
            failures++; $error("FAIL tick_count: observed %0d expected 4", tick_count);
        end

        loadTime(23, 59, 58, 0, "set_235958");
        applyStimulus(8, "day_wrap");

        mode_12h = 1'b1;
        loadTime(12, 0, 0, 0, "set_12am");
        loadTime(8, 0, 0, 1, "set_8pm");
        mode_12h = 1'b0; #1; checkOutput("mode_switch");

        loadTime(24, 0, 0, 0, "bad_24h");
        mode_12h = 1'b1;
        loadTime(0, 30, 0, 0, "bad_12h_zero");
        mode_12h = 1'b0;
        loadTime(10, 60, 0, 0, "bad_m1");
        loadTime(10, 20, 30, 0, "good_load");
        set_s0 = 4'hA; set = 1'b1; applyStimulus(1, "bad_s0"); set = 1'b0;

        for (int i = 0; i < CLK_DIV && cyc_in_sec != CLK_DIV - 1; i++) applyStimulus(1, "align");
        loadTime(1, 2, 3, 0, "set_on_tick");
        applyStimulus(CLK_DIV + 1, "after_set_tick");

        set_h1 = 4'd0; set_h0 = 4'd5; set = 1'b1;
        applyStimulus(6, "held_set");
        set = 1'b0;

        loadAlarm(24, 0, "bad_alarm");
        loadAlarm(0, 1, "alarm_0001");
        alarm_arm = 1'b1;
        loadTime(0, 0, 58, 0, "set_000058");
        applyStimulus(14, "alarm_run");
        alarm_ack = 1'b1; applyStimulus(1, "alarm_ack"); alarm_ack = 1'b0;
        applyStimulus(3, "after_ack");
        alarm_arm = 1'b0; applyStimulus(2, "disarm");

        applyStimulus(2, "mid_second");
        run = 1'b0; applyStimulus(20, "frozen");
        run = 1'b1; applyStimulus(6, "resume");

        for (int i = 0; i < 30; i++) begin
            mode_12h  = 1'($urandom_range(0, 1));
            run       = ($urandom_range(0, 3) != 0);
            alarm_arm = ($urandom_range(0, 3) != 0);
            alarm_ack = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0)
                loadAlarm($urandom_range(0, 24), $urandom_range(0, 61), "rand_alarm");
            if ($urandom_range(0, 1) == 0)
                loadTime($urandom_range(0, 24), $urandom_range(0, 61), $urandom_range(0, 61),
                         1'($urandom_range(0, 1)), "rand_set");
            applyStimulus($urandom_range(1, 10), "rand_run");
        end
        alarm_ack = 1'b0; run = 1'b1; mode_12h = 1'b0;

        set = 1'b1; rst = 1'b1;
        applyStimulus(1, "rst_in_set");
        set = 1'b0; rst = 1'b0;
        applyStimulus(CLK_DIV, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
